// File: rtl/riscv_pkg.sv
// Shared core definitions: register index width, the x0 index, load funct3
// codes and the load-queue entry layout used by the writeback unit.
package riscv_pkg;

    localparam int REG_W = 5;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // One outstanding load: where it writes and how to shape the raw word
    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [2:0]       funct3;
        logic [1:0]       addr_lo;
    } ldq_entry_t;

endpackage

// File: rtl/wb_ldq.sv
// Load queue: plain FIFO of outstanding load descriptors in issue order.
// Pushes while full and pops while empty are ignored internally.
module wb_ldq
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  ldq_entry_t din,
    input  logic       pop,
    output ldq_entry_t head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    ldq_entry_t        mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       cnt;
    logic              do_push;
    logic              do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == (AW+1)'(0));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array and write pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
        end else begin
            wr_ptr <= wr_ptr;
        end
    end

    // Read pointer and occupancy count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end else begin
                rd_ptr <= rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/wb_unit.sv
// Register-file writeback unit: merges ALU results and in-order load
// responses into one registered write port and tracks registers that have
// loads in flight so decode can stall on stale operands.
module wb_unit
    import riscv_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_issue,
    input  logic [REG_W-1:0] ld_rd,
    input  logic [2:0]       ld_funct3,
    input  logic [1:0]       ld_addr_lo,
    output logic             ld_ready,
    input  logic             mem_rvalid,
    input  logic [W-1:0]     mem_rdata,
    output logic             mem_rready,
    input  logic             alu_valid,
    input  logic [REG_W-1:0] alu_rd,
    input  logic [W-1:0]     alu_val,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    output logic             rs1_busy,
    output logic             rs2_busy,
    output logic             wen,
    output logic [REG_W-1:0] rd,
    output logic [W-1:0]     rd_val
);

    // Shape the raw aligned word according to the load type and byte offset
    function automatic logic [W-1:0] format_load(input logic [2:0] f3,
                                                 input logic [1:0] lo,
                                                 input logic [W-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [W-1:0] res;
        case (lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_LB:   res = {{(W-8){b[7]}}, b};
            F3_LBU:  res = {{(W-8){1'b0}}, b};
            F3_LH:   res = {{(W-16){h[15]}}, h};
            F3_LHU:  res = {{(W-16){1'b0}}, h};
            F3_LW:   res = word;
            default: res = word;
        endcase
        return res;
    endfunction

    ldq_entry_t       q_din;
    ldq_entry_t       q_head;
    logic             q_full;
    logic             q_empty;

    logic [31:0]      busy;
    logic [31:0]      busy_nxt;
    logic             hold_valid;
    logic [REG_W-1:0] hold_rd;
    logic [W-1:0]     hold_val;
    logic             wb_load;

    logic             ld_accept;
    logic             rsp_xfer;
    logic             alu_wr;

    // Full queue blocks issue even when a pop happens this cycle
    assign ld_ready   = !q_full && !(busy[ld_rd] && (ld_rd != REG_ZERO));
    assign ld_accept  = ld_issue && ld_ready;
    assign mem_rready = !q_empty && !hold_valid;
    assign rsp_xfer   = mem_rvalid && mem_rready;
    assign alu_wr     = alu_valid && (alu_rd != REG_ZERO);
    assign rs1_busy   = busy[rs1] && (rs1 != REG_ZERO);
    assign rs2_busy   = busy[rs2] && (rs2 != REG_ZERO);
    assign q_din      = '{rd: ld_rd, funct3: ld_funct3, addr_lo: ld_addr_lo};

    wb_ldq #(.DEPTH(DEPTH)) u_ldq (
        .clk   (clk),
        .rst   (rst),
        .push  (ld_accept),
        .din   (q_din),
        .pop   (rsp_xfer),
        .head  (q_head),
        .full  (q_full),
        .empty (q_empty)
    );

    // Busy bits: clear after a load commit to that register, set on accepted issue
    always_comb begin
        busy_nxt = '0;
        for (int i = 0; i < 32; i++) begin
            busy_nxt[i] = (busy[i] && !(wen && wb_load && (rd == 5'(i)))) ||
                          (ld_accept && (ld_rd == 5'(i)) && (ld_rd != REG_ZERO));
        end
    end

    // Scoreboard register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Write-port arbitration (ALU first) and the single-entry load hold buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen        <= 1'b0;
            rd         <= REG_ZERO;
            rd_val     <= '0;
            wb_load    <= 1'b0;
            hold_valid <= 1'b0;
            hold_rd    <= REG_ZERO;
            hold_val   <= '0;
        end else begin
            if (alu_wr) begin
                wen     <= 1'b1;
                rd      <= alu_rd;
                rd_val  <= alu_val;
                wb_load <= 1'b0;
            end else if (hold_valid) begin
                wen        <= 1'b1;
                rd         <= hold_rd;
                rd_val     <= hold_val;
                wb_load    <= 1'b1;
                hold_valid <= 1'b0;
            end else begin
                wen     <= 1'b0;
                wb_load <= 1'b0;
            end
            // Transfer only happens with hold empty, so it never races the drain above
            if (rsp_xfer && (q_head.rd != REG_ZERO)) begin
                hold_valid <= 1'b1;
                hold_rd    <= q_head.rd;
                hold_val   <= format_load(q_head.funct3, q_head.addr_lo, mem_rdata);
            end else begin
                hold_rd  <= hold_rd;
                hold_val <= hold_val;
            end
        end
    end

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed scenarios plus random traffic,
// all compared against a queue-based behavioural model.
module tb_wb_unit;

    localparam int W     = 32;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_issue = 1'b0;
    logic [4:0]  ld_rd = 5'd0;
    logic [2:0]  ld_funct3 = 3'd0;
    logic [1:0]  ld_addr_lo = 2'd0;
    logic        ld_ready;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_rready;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = 5'd0;
    logic [31:0] alu_val = 32'd0;
    logic [4:0]  rs1 = 5'd0;
    logic [4:0]  rs2 = 5'd0;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] rd_val;

    always #5 clk = ~clk;

    wb_unit #(.W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .ld_issue(ld_issue), .ld_rd(ld_rd), .ld_funct3(ld_funct3),
        .ld_addr_lo(ld_addr_lo), .ld_ready(ld_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rready(mem_rready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_val(alu_val),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wen(wen), .rd(rd), .rd_val(rd_val)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [4:0] rd;
        logic [2:0] f3;
        logic [1:0] a;
    } ent_t;

    ent_t        mq[$];
    bit          h_v;
    logic [4:0]  h_rd;
    logic [31:0] h_val;
    bit [31:0]   m_busy;
    bit          m_wen;
    bit          m_wload;
    logic [4:0]  m_rd;
    logic [31:0] m_val;

    function automatic logic [31:0] ref_fmt(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] w);
        longint v;
        case (f3)
            3'b000, 3'b100: begin
                v = longint'((w >> (8 * a)) & 32'hFF);
                if (f3 == 3'b000 && v >= 128) v = v - 256;
            end
            3'b001, 3'b101: begin
                v = longint'((w >> (16 * a[1])) & 32'hFFFF);
                if (f3 == 3'b001 && v >= 32768) v = v - 65536;
            end
            default: v = longint'(w);
        endcase
        return v[31:0];
    endfunction

    function automatic void model_reset();
        mq.delete();
        h_v = 1'b0; h_rd = 5'd0; h_val = 32'd0;
        m_busy = 32'd0;
        m_wen = 1'b0; m_wload = 1'b0; m_rd = 5'd0; m_val = 32'd0;
    endfunction

    // One clock: check combinational outputs, advance model and DUT, check write port
    task automatic step();
        bit   e_ldr, e_mrr, acc, xfer, alu_w;
        ent_t e;
        #1;
        e_ldr = (mq.size() < DEPTH) && !(m_busy[ld_rd] && ld_rd != 5'd0);
        e_mrr = (mq.size() != 0) && !h_v;
        check("ld_ready", ld_ready, e_ldr);
        check("mem_rready", mem_rready, e_mrr);
        check("rs1_busy", rs1_busy, m_busy[rs1] && rs1 != 5'd0);
        check("rs2_busy", rs2_busy, m_busy[rs2] && rs2 != 5'd0);
        acc   = ld_issue && e_ldr;
        xfer  = mem_rvalid && e_mrr;
        alu_w = alu_valid && alu_rd != 5'd0;
        @(posedge clk);
        if (m_wen && m_wload) m_busy[m_rd] = 1'b0;
        if (alu_w) begin
            m_wen = 1'b1; m_wload = 1'b0; m_rd = alu_rd; m_val = alu_val;
        end else if (h_v) begin
            m_wen = 1'b1; m_wload = 1'b1; m_rd = h_rd; m_val = h_val; h_v = 1'b0;
        end else begin
            m_wen = 1'b0; m_wload = 1'b0;
        end
        if (xfer) begin
            e = mq.pop_front();
            if (e.rd != 5'd0) begin
                h_v = 1'b1; h_rd = e.rd; h_val = ref_fmt(e.f3, e.a, mem_rdata);
            end
        end
        if (acc) begin
            e.rd = ld_rd; e.f3 = ld_funct3; e.a = ld_addr_lo;
            mq.push_back(e);
            if (ld_rd != 5'd0) m_busy[ld_rd] = 1'b1;
        end
        #1;
        check("wen", wen, m_wen);
        check("rd", rd, m_rd);
        check("rd_val", rd_val, m_val);
    endtask

    task automatic issue(input logic [4:0] r, input logic [2:0] f3, input logic [1:0] a);
        ld_issue = 1'b1; ld_rd = r; ld_funct3 = f3; ld_addr_lo = a;
        step();
        ld_issue = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d);
        mem_rvalid = 1'b1; mem_rdata = d;
        step();
        mem_rvalid = 1'b0;
    endtask

    task automatic fmt_test(input string tag, input logic [4:0] r, input logic [2:0] f3,
                            input logic [1:0] a, input logic [31:0] expv);
        issue(r, f3, a);
        respond(32'h80123456);
        step();
        check(tag, rd_val, expv);
        check({tag, "_rd"}, rd, r);
        step();
    endtask

    initial begin
        model_reset();
        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_wen", wen, 1'b0);
        check("rst_rd", rd, 5'd0);
        check("rst_rd_val", rd_val, 32'd0);
        check("rst_mem_rready", mem_rready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ALU path
        alu_valid = 1'b1; alu_rd = 5'd5; alu_val = 32'hDEADBEEF;
        step();
        check("alu_wen", wen, 1'b1);
        check("alu_rd", rd, 5'd5);
        check("alu_val", rd_val, 32'hDEADBEEF);
        alu_valid = 1'b0;
        step();
        check("alu_wen_off", wen, 1'b0);
        alu_valid = 1'b1; alu_rd = 5'd0; alu_val = 32'h12345678;
        step();
        check("alu_x0", wen, 1'b0);
        alu_valid = 1'b0;

        // Load formatting
        fmt_test("fmt_lb", 5'd7, 3'b000, 2'd3, 32'hFFFFFF80);
        fmt_test("fmt_lhu", 5'd8, 3'b101, 2'd2, 32'h00008012);
        fmt_test("fmt_lh", 5'd10, 3'b001, 2'd0, 32'h00003456);
        fmt_test("fmt_lw", 5'd11, 3'b010, 2'd0, 32'h80123456);

        // Scoreboard
        rs1 = 5'd9;
        issue(5'd9, 3'b010, 2'd0);
        ld_issue = 1'b1; ld_rd = 5'd9;
        #1;
        check("sb_busy", rs1_busy, 1'b1);
        check("sb_reissue", ld_ready, 1'b0);
        step();
        ld_issue = 1'b0;
        respond(32'hCAFEF00D);
        step();
        check("sb_wen", wen, 1'b1);
        check("sb_wen_rd", rd, 5'd9);
        #1;
        check("sb_busy_wen", rs1_busy, 1'b1);
        step();
        #1;
        check("sb_cleared", rs1_busy, 1'b0);

        // Collision: ALU beats the held load for two cycles
        issue(5'd3, 3'b010, 2'd0);
        issue(5'd12, 3'b010, 2'd0);
        respond(32'h33333333);
        alu_valid = 1'b1; alu_rd = 5'd4; alu_val = 32'hA1A1A1A1;
        mem_rvalid = 1'b1; mem_rdata = 32'h12121212;
        #1;
        check("col_rready", mem_rready, 1'b0);
        step();
        check("col_alu1", rd, 5'd4);
        alu_val = 32'hA2A2A2A2;
        step();
        check("col_alu2", rd_val, 32'hA2A2A2A2);
        alu_valid = 1'b0; mem_rvalid = 1'b0;
        step();
        check("col_load_rd", rd, 5'd3);
        check("col_load_val", rd_val, 32'h33333333);
        respond(32'h12121212);
        step();
        check("col_second", rd, 5'd12);
        step();

        // Queue full, push during pop rejected
        issue(5'd13, 3'b010, 2'd0);
        issue(5'd14, 3'b010, 2'd0);
        ld_issue = 1'b1; ld_rd = 5'd15;
        #1;
        check("full_ready", ld_ready, 1'b0);
        mem_rvalid = 1'b1; mem_rdata = 32'h13131313;
        step();
        ld_issue = 1'b0; mem_rvalid = 1'b0;
        step();
        respond(32'h14141414);
        step();
        check("full_drained", mem_rready, 1'b0);
        step();

        // Load to x0: consumed, nothing written
        issue(5'd0, 3'b010, 2'd0);
        respond(32'h0BADF00D);
        step();
        check("x0_wen", wen, 1'b0);
        check("x0_empty", mem_rready, 1'b0);

        // Mid-run reset with two loads pending
        rs1 = 5'd20;
        issue(5'd20, 3'b010, 2'd0);
        issue(5'd21, 3'b000, 2'd1);
        #1;
        check("mr_busy_pre", rs1_busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("mr_wen", wen, 1'b0);
        check("mr_rd", rd, 5'd0);
        check("mr_rd_val", rd_val, 32'd0);
        check("mr_busy", rs1_busy, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF; ld_rd = 5'd21;
        #1;
        check("mr_rready", mem_rready, 1'b0);
        check("mr_ld_ready", ld_ready, 1'b1);
        step();
        mem_rvalid = 1'b0;

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            ld_issue   = ($urandom_range(0, 2) == 0);
            ld_rd      = 5'($urandom_range(0, 7));
            ld_funct3  = 3'($urandom_range(0, 7));
            ld_addr_lo = 2'($urandom_range(0, 3));
            mem_rvalid = ($urandom_range(0, 1) == 1);
            mem_rdata  = $urandom;
            alu_valid  = ($urandom_range(0, 3) == 0);
            alu_rd     = 5'($urandom_range(0, 7));
            alu_val    = $urandom;
            rs1        = 5'($urandom_range(0, 7));
            rs2        = 5'($urandom_range(0, 7));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
